fbcd_fbin_conv: RTL and testbench
=================================

// Module: fbcd_fbin_conv
// PURPOSE
//   Converts one fractional BCD digit d (value 0.d) into a FRAC_BITS-wide binary
//   fraction, truncated toward zero: bin_out = floor(d * 2^FRAC_BITS / 10).
//   Used in the calculator datapath to turn the decimal digit after the point
//   into binary weights 2^-1..2^-FRAC_BITS.
//   The result is registered: one clock cycle of latency, one result per accepted input.
// PARAMETERS
//   FRAC_BITS  4  output fraction width; legal range 1..8. Output bit [FRAC_BITS-1]
//                 has weight 2^-1 and bit [0] has weight 2^-FRAC_BITS.
// PORTS
//   clk        in   1          rising-edge clock (single clock domain)
//   rst_n      in   1          asynchronous reset, active-low
//   in_valid   in   1          bcd_in is sampled on this clock edge
//   bcd_in     in   4          BCD digit d; bits 3..0 are weights 8,4,2,1
//   out_valid  out  1          result registers hold a new result this cycle
//   bin_out    out  FRAC_BITS  truncated binary fraction of 0.d
//   inexact    out  1          1 when d * 2^FRAC_BITS mod 10 != 0 (bits were lost)
//   err        out  1          1 when the input code is not BCD (10..15)
// BEHAVIOUR
//   Reset and clocking
//   - The single clock and the asynchronous active-low reset are already decided.
//   - While rst_n=0: out_valid=0, bin_out=0, inexact=0, err=0, asynchronously.
//   - Reset deasserts synchronously to clk. The first usable edge is the first
//     rising edge with rst_n=1.
//   Input acceptance
//   - On a rising edge with in_valid=1: register out_valid=1 and the converted
//     bin_out, inexact and err.
//   - Latency is exactly 1 cycle. Back-to-back inputs give back-to-back results.
//   - There is no backpressure.
//   - On a rising edge with in_valid=0: out_valid=0. bin_out, inexact and err keep
//     their last values.
//   Arithmetic
//   - Compute p = d * 2^FRAC_BITS, which needs 4+FRAC_BITS bits.
//   - bin_out = p / 10 (integer quotient). inexact = (p % 10 != 0).
//   - Equivalent to FRAC_BITS rounds of doubling: r <- 2r; emit bit (r>=10);
//     if the bit is 1, r <- r-10. Bits come out MSB first, starting from r=d.
//   - The conversion is a pure function evaluated in one cycle. It needs no
//     multiplier, only a constant divide by 10 or the unrolled doubling.
//   - FRAC_BITS=4 table, d -> bin_out:
//     0->0000, 1->0001, 2->0011, 3->0100, 4->0110,
//     5->1000, 6->1001, 7->1011, 8->1100, 9->1110.
//   - With FRAC_BITS=4, inexact=0 only for d=0 and d=5.
//   Invalid input
//   - Codes 10..15 set err=1, bin_out all ones and inexact=0. out_valid still
//     asserts.
//   Reset mid-operation
//   - Asserting rst_n=0 while a result is pending clears that result immediately.
//     No output is produced for the input that was in flight.
// TESTING
//   1 Assert rst_n=0 mid-stream -> all outputs go to 0 without waiting for clk;
//     no result is produced for the pending input.
//   2 FRAC_BITS=4: sweep d=0..9 with in_valid=1 on consecutive cycles ->
//     bin_out follows the table one cycle later, out_valid stays high, err=0.
//   3 d=5 -> bin_out=1000, inexact=0. d=9 -> bin_out=1110, inexact=1.
//     d=0 -> bin_out=0000, inexact=0.
//   4 bcd_in=4'hA and 4'hF -> err=1, bin_out=1111, out_valid=1.
//     Next input d=3 -> err=0, bin_out=0100.
//   5 in_valid pulsed every 3rd cycle -> out_valid is a 1-cycle pulse after each
//     accepted input. bin_out holds its value while out_valid=0.
//   6 FRAC_BITS=8 -> d=1 gives 0x19 (inexact=1), d=5 gives 0x80 (inexact=0),
//     d=9 gives 0xE6 (inexact=1).

Source files
------------

// File: rtl/fbcd_fbin_conv.sv
// rtl/fbcd_fbin_conv.sv - fractional BCD digit to truncated binary fraction, 1-cycle latency
module fbcd_fbin_conv #(
  parameter int FRAC_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [3:0]           bcd_in,
  output logic                 out_valid,
  output logic [FRAC_BITS-1:0] bin_out,
  output logic                 inexact,
  output logic                 err
);

  logic                 w_err;
  logic                 w_inexact;
  logic [FRAC_BITS-1:0] w_bin;
  logic [4:0]           w_rem;

  // Unrolled long division of 0.d by doubling: each round emits one fraction bit, MSB first.
  // The remainder stays below 10 for legal digits, so 2r never exceeds 18 and fits in 5 bits.
  always_comb begin
    w_err     = (bcd_in > 4'd9);
    w_bin     = '0;
    w_inexact = 1'b0;
    w_rem     = {1'b0, bcd_in};
    for (int i = FRAC_BITS - 1; i >= 0; i--) begin
      w_rem = w_rem << 1;
      if (w_rem >= 5'd10) begin
        w_bin[i] = 1'b1;
        w_rem    = w_rem - 5'd10;
      end
    end
    if (w_err) begin
      w_bin     = '1;
      w_inexact = 1'b0;
    end else begin
      w_inexact = (w_rem != 5'd0);
    end
  end

  // Result registers: out_valid tracks in_valid; data fields only update on accepted inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      bin_out   <= '0;
      inexact   <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        bin_out <= w_bin;
        inexact <= w_inexact;
        err     <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_fbcd_fbin_conv.sv
// tb/tb_fbcd_fbin_conv.sv - randomized self-checking bench for fbcd_fbin_conv (FRAC_BITS 4 and 8)
module tb_fbcd_fbin_conv;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] bcd_in;

  logic       ov4, ix4, er4;
  logic [3:0] b4;
  logic       ov8, ix8, er8;
  logic [7:0] b8;

  int n_tests;
  int n_fail;

  // reference model state: what the output registers should hold
  logic        m_ov;
  logic        m_er;
  logic [31:0] m_b4, m_b8;
  logic        m_ix4, m_ix8;

  fbcd_fbin_conv #(.FRAC_BITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .bcd_in(bcd_in),
    .out_valid(ov4), .bin_out(b4), .inexact(ix4), .err(er4)
  );

  fbcd_fbin_conv #(.FRAC_BITS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .bcd_in(bcd_in),
    .out_valid(ov8), .bin_out(b8), .inexact(ix8), .err(er8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // 0.d * 2^fb, integer quotient and remainder test
  task automatic ref_conv(input int d, input int fb, output logic [31:0] q, output logic ix);
    int p;
    if (d > 9) begin
      q  = (32'd1 << fb) - 32'd1;
      ix = 1'b0;
    end else begin
      p  = d * (1 << fb);
      q  = p / 10;
      ix = (p % 10) != 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ov4"}, {31'd0, ov4}, {31'd0, m_ov});
    chk({tag, ".b4"},  {28'd0, b4},  m_b4);
    chk({tag, ".ix4"}, {31'd0, ix4}, {31'd0, m_ix4});
    chk({tag, ".er4"}, {31'd0, er4}, {31'd0, m_er});
    chk({tag, ".ov8"}, {31'd0, ov8}, {31'd0, m_ov});
    chk({tag, ".b8"},  {24'd0, b8},  m_b8);
    chk({tag, ".ix8"}, {31'd0, ix8}, {31'd0, m_ix8});
    chk({tag, ".er8"}, {31'd0, er8}, {31'd0, m_er});
  endtask

  task automatic model_reset();
    m_ov = 1'b0; m_er = 1'b0;
    m_b4 = '0; m_b8 = '0; m_ix4 = 1'b0; m_ix8 = 1'b0;
  endtask

  // drive one cycle of input, let the edge happen, then check just after it
  task automatic apply(input logic v, input logic [3:0] d, input string tag);
    in_valid = v;
    bcd_in   = d;
    @(posedge clk);
    #1;
    m_ov = v;
    if (v) begin
      ref_conv(int'(d), 4, m_b4, m_ix4);
      ref_conv(int'(d), 8, m_b8, m_ix8);
      m_er = (d > 4'd9);
    end
    check_all(tag);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    bcd_in   = 4'd0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // literal table and FRAC_BITS=8 spot checks alongside the model
    for (int d = 0; d < 10; d++) begin
      apply(1'b1, 4'(d), "sweep");
      case (d)
        0: chk("tbl4_0", {28'd0, b4}, 32'h0);
        3: chk("tbl4_3", {28'd0, b4}, 32'h4);
        5: chk("tbl4_5", {28'd0, b4}, 32'h8);
        9: chk("tbl4_9", {28'd0, b4}, 32'hE);
        default: ;
      endcase
      if (d == 1) chk("tbl8_1", {24'd0, b8}, 32'h19);
      if (d == 5) chk("tbl8_5", {24'd0, b8}, 32'h80);
      if (d == 9) chk("tbl8_9", {24'd0, b8}, 32'hE6);
    end

    apply(1'b1, 4'hA, "bad_a");
    chk("bad_a_lit", {28'd0, b4}, 32'hF);
    apply(1'b1, 4'hF, "bad_f");
    apply(1'b1, 4'd3, "after_bad");
    chk("after_bad_lit", {28'd0, b4}, 32'h4);
    apply(1'b1, 4'd5, "d5");
    apply(1'b1, 4'd9, "d9");
    apply(1'b1, 4'd0, "d0");

    // accepted input every third cycle
    for (int k = 0; k < 12; k++) begin
      apply(1'b1, 4'($urandom_range(0, 9)), "pulse_v");
      apply(1'b0, 4'($urandom_range(0, 15)), "pulse_h1");
      apply(1'b0, 4'($urandom_range(0, 15)), "pulse_h2");
    end

    // fully random traffic including illegal codes
    for (int k = 0; k < 300; k++) begin
      apply(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "rand");
    end

    // asynchronous reset with an input in flight
    apply(1'b1, 4'd7, "pre_rst");
    in_valid = 1'b1;
    bcd_in   = 4'd2;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    in_valid = 1'b0;
    rst_n    = 1'b1;
    apply(1'b0, 4'd2, "post_rst");
    apply(1'b1, 4'd6, "post_rst_v");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
